// File: rtl/vga_scanout_reader_if.sv
// Memory read bus and pixel stream of the VGA scanout reader.
// The master modport is the reader side; the slave modport is memory plus pixel sink.
interface vga_scanout_reader_if;
    logic [14:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;

    modport master (
        output mem_address,
        output mem_chipselect,
        output mem_write,
        output mem_byteenable,
        input  mem_readdata,
        output pix_data,
        output pix_valid,
        input  pix_ready,
        output pix_sof
    );

    modport slave (
        input  mem_address,
        input  mem_chipselect,
        input  mem_write,
        input  mem_byteenable,
        output mem_readdata,
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        input  pix_sof
    );
endinterface

// File: rtl/vga_scanout_reader.sv
// Fetches framebuffer words from on-chip memory and streams them out as
// little-endian 8-bit pixels through a small word FIFO.
module vga_scanout_reader #(
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = 4800,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic frame_start,
    output logic frame_wrap,
    vga_scanout_reader_if.master bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [14:0] FIRST_ADDR = 15'(BASE_ADDR);
    localparam logic [14:0] LAST_ADDR  = 15'(BASE_ADDR + FRAME_WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [14:0]     addr_q, addr_d;
    logic            cs_q, cs_d;
    logic            wrap_q, wrap_d;
    logic            pend_q, pend_d;
    logic            pend_sof_q, pend_sof_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]      idx_q, idx_d;

    logic [31:0]           word_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] sof_mem;

    logic        flush_c, push_c, valid_c, xfer_c, pop_c;
    logic [31:0] head_c;
    logic [7:0]  byte_c;

    // A restart (frame_start in RUN) or disable drops everything queued or in flight
    assign flush_c = !enable || (state_q == RUN && frame_start);
    assign push_c  = pend_q && !flush_c;
    assign valid_c = (count_q != '0) && !flush_c;
    assign xfer_c  = valid_c && bus.pix_ready;
    assign pop_c   = xfer_c && (idx_q == 2'd3);

    always_comb begin
        head_c = word_mem[rd_ptr_q];
        case (idx_q)
            2'd0:    byte_c = head_c[7:0];
            2'd1:    byte_c = head_c[15:8];
            2'd2:    byte_c = head_c[23:16];
            default: byte_c = head_c[31:24];
        endcase
    end

    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = cs_q;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.pix_valid      = valid_c;
    assign bus.pix_data       = valid_c ? byte_c : 8'h00;
    assign bus.pix_sof        = valid_c && sof_mem[rd_ptr_q] && (idx_q == 2'd0);
    assign frame_wrap         = wrap_q;

    // Next-state: FSM, address walk, FIFO bookkeeping and request budget
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cs_d       = 1'b0;
        wrap_d     = 1'b0;
        pend_d     = 1'b0;
        pend_sof_d = 1'b0;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        idx_d      = idx_q;

        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush_c) begin
            addr_d   = FIRST_ADDR;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            idx_d    = 2'd0;
        end else begin
            if (cs_q) begin
                pend_d     = 1'b1;
                pend_sof_d = (addr_q == FIRST_ADDR);
                addr_d     = (addr_q == LAST_ADDR) ? FIRST_ADDR : addr_q + 15'd1;
            end
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (xfer_c) idx_d = idx_q + 2'd1;
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end

        // Stored words plus the read still returning must leave room for this one
        if (state_d == RUN && (count_d + CW'(pend_d)) < CW'(FIFO_DEPTH)) begin
            cs_d   = 1'b1;
            wrap_d = (addr_d == LAST_ADDR);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= FIRST_ADDR;
            cs_q       <= 1'b0;
            wrap_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_sof_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            idx_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cs_q       <= cs_d;
            wrap_q     <= wrap_d;
            pend_q     <= pend_d;
            pend_sof_q <= pend_sof_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            idx_q      <= idx_d;
        end
    end

    // FIFO storage; contents are masked at the outputs while empty, so no reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            word_mem[wr_ptr_q] <= bus.mem_readdata;
            sof_mem[wr_ptr_q]  <= pend_sof_q;
        end
    end

endmodule

// File: doc/vga_scanout_reader.md
VGA_SCANOUT_READER -- requirements
Module: vga_scanout_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0: word address of the first framebuffer word.
REQ-002 SHALL have parameter FRAME_WORDS, default 4800: words per frame (160x120 pixels, 8 bpp).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: word FIFO entries, power of two, minimum 4.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port enable  in  1  level; 1 = scan out, 0 = idle and flushed.
REQ-008 SHALL have port frame_start  in  1  single-cycle pulse; restart frame at BASE_ADDR.
REQ-009 SHALL have port mem_address  out  15  word address to the on-chip memory.
REQ-010 SHALL have port mem_chipselect  out  1  read request strobe.
REQ-011 SHALL have port mem_write  out  1  constant 0.
REQ-012 SHALL have port mem_byteenable  out  4  constant 4'hF.
REQ-013 SHALL have port mem_readdata  in  32  memory read data, valid exactly 1 cycle after a request.
REQ-014 SHALL have port pix_data  out  8  pixel value.
REQ-015 SHALL have port pix_valid  out  1  pixel available.
REQ-016 SHALL have port pix_ready  in  1  downstream accepts pixel.
REQ-017 SHALL have port pix_sof  out  1  qualifies pix_data as pixel 0 of a frame.
REQ-018 SHALL have port frame_wrap  out  1  one-cycle pulse when the last word of a frame is requested.

Function
REQ-019 SHALL implement states IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-020 SHALL, in IDLE, hold mem_chipselect=0 and pix_valid=0, empty the FIFO, and set the word address to BASE_ADDR.
REQ-021 SHALL, in RUN, assert mem_chipselect for exactly one cycle per word when (FIFO occupancy + outstanding reads) < FIFO_DEPTH, issuing at most one request per cycle.
REQ-022 SHALL write mem_readdata into the FIFO on the cycle after each non-discarded request; readdata is never registered earlier than that.
REQ-023 SHALL increment mem_address after each request; after BASE_ADDR+FRAME_WORDS-1 it wraps to BASE_ADDR, and frame_wrap pulses in that request cycle.
REQ-024 SHALL unpack each FIFO word little-endian: pixels in order [7:0], [15:8], [23:16], [31:24].
REQ-025 SHALL transfer a pixel on a cycle with pix_valid=1 and pix_ready=1; pix_data and pix_sof hold stable while pix_valid=1 and pix_ready=0.
REQ-026 SHALL pop the FIFO word on transfer of its fourth pixel; with a following word present, pix_valid stays 1 with no bubble.
REQ-027 SHALL drive pix_sof=1 only for pixel [7:0] of a word fetched from BASE_ADDR.
REQ-028 SHALL, on frame_start=1 in RUN, flush the FIFO and pixel index, discard the read in flight (its data cycle is not stored), and issue the next request from BASE_ADDR no later than the following cycle.
REQ-029 SHALL give frame_start priority over a simultaneous FIFO push or pixel transfer; no pixel is transferred in that cycle.
REQ-030 SHALL ignore frame_start in IDLE.
REQ-031 SHALL give enable=0 the same flush semantics as frame_start and discard an in-flight read.
REQ-032 SHALL never overflow the FIFO: a full FIFO suppresses requests, and an empty FIFO drives pix_valid=0.

Reset
REQ-033 SHALL, while reset_n=0, force the state to IDLE, mem_address=BASE_ADDR, mem_chipselect=0, pix_valid=0, pix_sof=0, frame_wrap=0, pix_data=0, FIFO empty, and no outstanding read.
REQ-034 SHALL take reset asynchronously and release it synchronously to clk; the first request occurs no earlier than the cycle after release with enable=1.

Verification
REQ-035 SHALL be checked with this scenario: memory word0=32'h44332211, enable=1, pix_ready=1 -> pixels 11,22,33,44; pix_sof only on 11; first request on the cycle after enable.
REQ-036 SHALL be checked with this scenario: FRAME_WORDS=4, continuous ready -> addresses 0,1,2,3,0,...; frame_wrap pulses with address 3; pix_sof recurs every 16 pixels.
REQ-037 SHALL be checked with this scenario: pix_ready=0 for 50 cycles -> exactly FIFO_DEPTH requests are issued, then mem_chipselect=0; pix_data stays stable; no word is lost after release.
REQ-038 SHALL be checked with this scenario: frame_start after 6 pixels, issued in the same cycle as a read in flight -> the stale word is dropped; the next pixel is word0 byte0 with pix_sof=1.
REQ-039 SHALL be checked with this scenario: enable dropped mid-frame, then raised -> pix_valid=0 within 1 cycle; on restart the stream begins at BASE_ADDR with pix_sof=1.
REQ-040 SHALL be checked with this scenario: reset_n asserted mid-frame, asynchronous to clk -> all outputs take their reset values immediately; after release the frame restarts from BASE_ADDR.
